// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS BCD stopwatch counting synchronised tick edges, gated by a start/stop/clear/lap FSM.
module stopwatch_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, PAUSE = 2'd3} state_t;
  // digit limits, index 0 = seconds ones
  localparam logic [3:0][3:0] LIM = {4'd5, 4'd9, 4'd5, 4'd9};
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic [3:0][3:0] live_q, live_d, lap_q, lap_d, disp;
  logic wrap_q, wrap_d;
  logic tick_pulse, count_en, carry;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], tick_in};
    prev_d = sync_q[SYNC_STAGES-1];
    tick_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
    count_en = tick_pulse && (state_q == RUN || state_q == LAP);
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = start_stop ? RUN : IDLE;
      RUN:   state_d = start_stop ? PAUSE : lap ? LAP : RUN;
      LAP:   state_d = start_stop ? PAUSE : lap ? RUN : LAP;
      PAUSE: state_d = clear ? IDLE : start_stop ? RUN : PAUSE;
    endcase
    carry = count_en;
    live_d = live_q;
    for (int i = 0; i < 4; i++) begin
      live_d[i] = carry ? (live_q[i] == LIM[i] ? 4'd0 : live_q[i] + 4'd1) : live_q[i];
      carry = carry && live_q[i] == LIM[i];
    end
    wrap_d = carry;
    if (state_q == PAUSE && clear) live_d = '0;
    // lap snapshot takes the pre-increment count
    lap_d = (state_q == RUN && state_d == LAP) ? live_q : lap_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q <= '0;
      prev_q <= 1'b0;
      live_q <= '0;
      lap_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      live_q <= live_d;
      lap_q <= lap_d;
      wrap_q <= wrap_d;
    end
  end
  assign disp = state_q == LAP ? lap_q : live_q;
  assign sec_ones = disp[0];
  assign sec_tens = disp[1];
  assign min_ones = disp[2];
  assign min_tens = disp[3];
  assign running = state_q == RUN || state_q == LAP;
  assign lap_active = state_q == LAP;
  assign wrap = wrap_q;
  assign state = state_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: random and directed stimulus against a seconds-count reference model.
module tb_stopwatch_core;
  logic clk = 1'b0, rst = 1'b1, tick_in = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic running, lap_active, wrap;
  logic [1:0] state;
  int checks = 0, failures = 0, wrap_seen = 0;
  int m_state = 0, m_cnt = 0, m_lap = 0;
  bit m_wrap = 0, h1 = 0, h2 = 0, h3 = 0;

  stopwatch_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
    .running(running), .lap_active(lap_active), .wrap(wrap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // one clock edge: advance the model with the inputs present at the edge, then compare
  task automatic step();
    int nst;
    bit pulse, en;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_cnt = 0; m_lap = 0; m_wrap = 0; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      pulse = h2 && !h3;
      en = pulse && (m_state == 1 || m_state == 2);
      nst = m_state;
      if (m_state == 0 && start_stop) nst = 1;
      else if (m_state == 1) nst = start_stop ? 3 : lap ? 2 : 1;
      else if (m_state == 2) nst = start_stop ? 3 : lap ? 1 : 2;
      else if (m_state == 3) nst = clear ? 0 : start_stop ? 1 : 3;
      if (m_state == 1 && nst == 2) m_lap = m_cnt;
      m_wrap = en && m_cnt == 3599;
      if (en) m_cnt = (m_cnt + 1) % 3600;
      if (m_state == 3 && clear) m_cnt = 0;
      m_state = nst;
      h3 = h2; h2 = h1; h1 = tick_in;
    end
    #1;
    check("disp", disp(), bcd(m_state == 2 ? m_lap : m_cnt));
    check("state", state, m_state);
    check("running", running, m_state == 1 || m_state == 2);
    check("lap_active", lap_active, m_state == 2);
    check("wrap", wrap, m_wrap);
    if (wrap) wrap_seen++;
    start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      tick_in = 1; step(); step();
      tick_in = 0; step(); step();
    end
  endtask

  task automatic rstep();
    int r;
    r = $urandom_range(0, 15);
    start_stop = (r == 0 || r == 3);
    clear = (r == 1 || r == 3 || r == 5);
    lap = (r == 2 || r == 5 || r == 6);
    rst = ($urandom_range(0, 299) == 0);
    step();
  endtask

  initial begin
    tick_in = 1; rst = 1;
    repeat (3) step();
    rst = 0;
    repeat (5) step();
    check("idle_disp", disp(), 16'h0000);
    check("idle_state", state, 2'd0);
    tick_in = 0; step(); step();
    start_stop = 1; step();
    tick(12);
    check("t12_disp", disp(), 16'h0012);
    check("t12_running", running, 1'b1);
    start_stop = 1; step();
    clear = 1; step();
    start_stop = 1; step();
    tick(3598);
    check("pre_wrap", disp(), 16'h5958);
    tick(1);
    check("max", disp(), 16'h5959);
    wrap_seen = 0;
    tick(1);
    check("wrapped", disp(), 16'h0000);
    check("wrap_once", wrap_seen, 1);
    tick(7);
    lap = 1; step();
    tick(5);
    check("lap_hold", disp(), 16'h0007);
    check("lap_active", lap_active, 1'b1);
    lap = 1; step();
    check("lap_exit", disp(), 16'h0012);
    start_stop = 1; step();
    clear = 1; step();
    start_stop = 1; step();
    tick(3);
    start_stop = 1; clear = 1; step();
    check("ss_clr_state", state, 2'd3);
    check("ss_clr_disp", disp(), 16'h0003);
    clear = 1; step();
    check("clr_state", state, 2'd0);
    check("clr_disp", disp(), 16'h0000);
    start_stop = 1; step();
    tick_in = 1; step(); step();
    tick_in = 0; start_stop = 1; step();
    check("edge_stop_state", state, 2'd3);
    check("edge_stop_disp", disp(), 16'h0001);
    tick(3);
    check("paused_disp", disp(), 16'h0001);
    repeat (600) begin
      tick_in = 1;
      repeat ($urandom_range(2, 4)) rstep();
      tick_in = 0;
      repeat ($urandom_range(2, 4)) rstep();
    end
    rst = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
